tenthirty_core_multi: RTL
=========================

Name: tenthirty_core_multi

Overview:
- Parametrised game engine for ten-and-a-half, generalised from the single-player board game to NUM_PLAYERS players plus a dealer.
- Runs the round state machine, hand scoring, the five-card rule, dealer auto-play and per-player result evaluation.
- Cards come from an external deck block over a req/ack handshake. Buttons are sampled on an internal divided tick.
- Seven-segment rendering stays in the separate display block, which reads the score/result outputs.

Parameters:
- NUM_PLAYERS, 1, number of players (1..4); PW = max(1, clog2(NUM_PLAYERS)).
- MAX_CARDS, 5, card count at which a hand auto-stands (five-card rule).
- DIV_BIT, 4, tick period = 2^(DIV_BIT+1) clk cycles.
- DEALER_STAND, 14, dealer stops drawing once score >= this value (half-points; 14 = 7.0).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- btn_m  in  1  start round / draw card
- btn_r  in  1  stand / pass turn
- card_val  in  4  card rank 1..13, sampled when card_ack=1
- card_ack  in  1  deck has card_val valid this cycle
- card_req  out  1  request one card
- cur_player  out  PW  player whose turn it is
- dealer_turn  out  1  dealer is drawing
- player_score  out  6*NUM_PLAYERS  half-point scores, player 0 in LSBs
- dealer_score  out  6  dealer half-point score
- result  out  2*NUM_PLAYERS  per player: 00 none, 01 win, 10 lose, 11 tie
- result_valid  out  1  high in RESULT
- led  out  3  player 0 outcome: {win, tie, lose}

Behaviour:
- Reset (sync, rst_n=0 at posedge):
  - state=IDLE; divider counter=0.
  - All scores, card counts, result, result_valid, led, card_req, cur_player and dealer_turn are 0.
  - Applies mid-handshake too: card_req drops at that edge, and any in-flight ack is ignored.
- Tick:
  - Free-running counter; tick=1 for one clk when counter[DIV_BIT:0] is all ones.
  - At each tick, btn_m/btn_r are registered.
  - An edge event is tick & btn & ~btn_prev.
  - Edges arriving in states that do not consume them are discarded, not queued.
- Card value, added to the target hand (6-bit unsigned):
  - 1..10 add 2*v.
  - 11, 12, 13 add 1.
  - 0, 14, 15 are ignored: ack is consumed, count and score unchanged, card_req stays high.
- State IDLE: btn_m edge
  - clears scores, counts and result;
  - sets cur_player=0;
  - goes to REQ with target = player 0.
- State REQ:
  - card_req=1 from the first REQ cycle until the cycle card_ack=1; it deasserts the next cycle.
  - The card is applied on the ack edge (one-cycle latency ack -> score).
  - Then evaluate the target hand.
- Player evaluation:
  - score > 21 (bust) or count == MAX_CARDS -> next-player.
  - Otherwise -> PLAY.
- State PLAY:
  - btn_m edge -> REQ for cur_player.
  - btn_r edge -> next-player.
  - Simultaneous edges: btn_r wins.
- Next-player:
  - If cur_player < NUM_PLAYERS-1: cur_player++ and REQ for the new player (first card dealt automatically).
  - Otherwise dealer_turn=1 and REQ for the dealer.
- Dealer evaluation:
  - score > 21, count == MAX_CARDS, or score >= DEALER_STAND -> RESULT.
  - Otherwise REQ immediately (no tick wait).
  - The dealer always plays, even if all players bust.
- State RESULT, per player:
  - Player bust -> lose.
  - Else player five-card -> win.
  - Else dealer bust -> win.
  - Else higher score wins; equal -> tie.
  - result_valid=1; led reflects player 0.
  - btn_m edge starts a new round exactly as from IDLE.
  - Scores hold until then.

Optional Feature:
- Macro TENTHIRTY_AUTOSTAND_EN.
- When defined: a player hand reaching exactly 21 (10.5) goes to next-player immediately after evaluation, without waiting for btn_r.
- When undefined: the player stays in PLAY at 21; a further btn_m draw is allowed (and will bust).

Test Plan:
1. Reset: rst_n=0 for 4 clk -> card_req=0, all scores 0, result=0, led=000, result_valid=0; hold 100 clk idle -> no card_req.
2. NUM_PLAYERS=1, btn_m held 4 ticks:
   - Exactly one card_req; ack card_val=3 -> player_score=6.
   - btn_r -> dealer_turn=1; ack 10 -> dealer_score=20 -> RESULT, result=10, led=001.
3. Face card plus dealer draws:
   - Player acks 12 then 10 -> score 21; btn_r.
   - Dealer acks 5, 13, 2 -> 10, 11, 15, then stops.
   - result=01, led=100.
4. Bust: player acks 7 then 8 -> score 30 -> turn ends with no btn_r; dealer acks 10 -> result=10 (lose).
5. Five-card: player acks 13 x5 -> score 5, auto-stand; dealer acks 10 -> result=01. card_val=0 ack -> no score change, card_req stays high.
6. NUM_PLAYERS=2, and reset during REQ:
   - btn_r on player 0 -> cur_player=1 and an auto card_req.
   - rst_n=0 while card_req=1 -> card_req=0 next edge and state IDLE.
   - With TENTHIRTY_AUTOSTAND_EN: reaching 21 advances cur_player without btn_r.

Source files
------------

// File: rtl/tenthirty_core_multi.sv
// Ten-and-a-half round engine for NUM_PLAYERS players plus an auto-playing dealer.
// Define TENTHIRTY_AUTOSTAND_EN to end a player's turn automatically on exactly 21 half-points.
module tenthirty_lane #(
    parameter int CW        = 3,
    parameter int MAX_CARDS = 5
) (
    input  logic [5:0]    p_score,
    input  logic [CW-1:0] p_cnt,
    input  logic [5:0]    d_score,
    output logic [1:0]    res
);
    always_comb begin
        if (p_score > 6'd21)                res = 2'b10;
        else if (p_cnt == CW'(MAX_CARDS))   res = 2'b01;
        else if (d_score > 6'd21)           res = 2'b01;
        else if (p_score > d_score)         res = 2'b01;
        else if (p_score == d_score)        res = 2'b11;
        else                                res = 2'b10;
    end
endmodule

module tenthirty_core_multi #(
    parameter int NUM_PLAYERS  = 1,
    parameter int MAX_CARDS    = 5,
    parameter int DIV_BIT      = 4,
    parameter int DEALER_STAND = 14,
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     btn_m,
    input  logic                     btn_r,
    input  logic [3:0]               card_val,
    input  logic                     card_ack,
    output logic                     card_req,
    output logic [PW-1:0]            cur_player,
    output logic                     dealer_turn,
    output logic [6*NUM_PLAYERS-1:0] player_score,
    output logic [5:0]               dealer_score,
    output logic [2*NUM_PLAYERS-1:0] result,
    output logic                     result_valid,
    output logic [2:0]               led
);
    localparam int CW = $clog2(MAX_CARDS + 1);

    typedef enum logic [2:0] {IDLE, REQ, EVAL, PLAY, RESULT} state_t;
    state_t state;

    logic [DIV_BIT:0]                   div_cnt;
    logic                               bm_prev, br_prev;
    logic [NUM_PLAYERS-1:0][5:0]        p_score;
    logic [NUM_PLAYERS-1:0][CW-1:0]     p_cnt;
    logic [5:0]                         d_score;
    logic [CW-1:0]                      d_cnt;
    logic [NUM_PLAYERS-1:0][1:0]        res_w;
    logic [5:0]                         card_pts, tgt_score;
    logic [CW-1:0]                      tgt_cnt;
    logic                               card_ok, p_done, d_done, next_pl;

    wire tick   = &div_cnt;
    wire m_edge = tick & btn_m & ~bm_prev;
    wire r_edge = tick & btn_r & ~br_prev;

    assign player_score = p_score;
    assign dealer_score = d_score;

    always_comb begin
        card_pts = 6'd0;
        card_ok  = 1'b0;
        if (card_val >= 4'd1 && card_val <= 4'd10) begin
            card_pts = {1'b0, card_val, 1'b0};
            card_ok  = 1'b1;
        end else if (card_val >= 4'd11 && card_val <= 4'd13) begin
            card_pts = 6'd1;
            card_ok  = 1'b1;
        end
    end

    // Hand currently being dealt to: dealer once dealer_turn is set, else cur_player.
    always_comb begin
        tgt_score = d_score;
        tgt_cnt   = d_cnt;
        if (!dealer_turn)
            for (int i = 0; i < NUM_PLAYERS; i++)
                if (cur_player == PW'(i)) begin
                    tgt_score = p_score[i];
                    tgt_cnt   = p_cnt[i];
                end
    end

    always_comb begin
        p_done = (tgt_score > 6'd21) || (tgt_cnt == CW'(MAX_CARDS));
`ifdef TENTHIRTY_AUTOSTAND_EN
        p_done = p_done || (tgt_score == 6'd21);
`endif
        d_done  = (tgt_score > 6'd21) || (tgt_cnt == CW'(MAX_CARDS)) ||
                  (tgt_score >= 6'(DEALER_STAND));
        next_pl = ((state == EVAL) && !dealer_turn && p_done) || ((state == PLAY) && r_edge);
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_lane
        tenthirty_lane #(.CW(CW), .MAX_CARDS(MAX_CARDS)) u_lane (
            .p_score (p_score[g]),
            .p_cnt   (p_cnt[g]),
            .d_score (d_score),
            .res     (res_w[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bm_prev      <= 1'b0;
            br_prev      <= 1'b0;
            p_score      <= '0;
            p_cnt        <= '0;
            d_score      <= '0;
            d_cnt        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            led          <= 3'b000;
            card_req     <= 1'b0;
            cur_player   <= '0;
            dealer_turn  <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (tick) begin
                bm_prev <= btn_m;
                br_prev <= btn_r;
            end
            if (next_pl) begin
                if (int'(cur_player) < NUM_PLAYERS - 1) cur_player <= cur_player + 1'b1;
                else                                    dealer_turn <= 1'b1;
                card_req <= 1'b1;
                state    <= REQ;
            end else begin
                case (state)
                    IDLE, RESULT: if (m_edge) begin
                        p_score      <= '0;
                        p_cnt        <= '0;
                        d_score      <= '0;
                        d_cnt        <= '0;
                        result       <= '0;
                        result_valid <= 1'b0;
                        led          <= 3'b000;
                        cur_player   <= '0;
                        dealer_turn  <= 1'b0;
                        card_req     <= 1'b1;
                        state        <= REQ;
                    end
                    // Out-of-range ranks are swallowed; card_req stays up for a real card.
                    REQ: if (card_ack && card_ok) begin
                        if (dealer_turn) begin
                            d_score <= d_score + card_pts;
                            d_cnt   <= d_cnt + 1'b1;
                        end else begin
                            for (int i = 0; i < NUM_PLAYERS; i++)
                                if (cur_player == PW'(i)) begin
                                    p_score[i] <= p_score[i] + card_pts;
                                    p_cnt[i]   <= p_cnt[i] + 1'b1;
                                end
                        end
                        card_req <= 1'b0;
                        state    <= EVAL;
                    end
                    EVAL: if (!dealer_turn) begin
                        state <= PLAY;
                    end else if (d_done) begin
                        result       <= res_w;
                        result_valid <= 1'b1;
                        dealer_turn  <= 1'b0;
                        case (res_w[0])
                            2'b01:   led <= 3'b100;
                            2'b11:   led <= 3'b010;
                            2'b10:   led <= 3'b001;
                            default: led <= 3'b000;
                        endcase
                        state <= RESULT;
                    end else begin
                        card_req <= 1'b1;
                        state    <= REQ;
                    end
                    PLAY: if (m_edge) begin
                        card_req <= 1'b1;
                        state    <= REQ;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
